// File: rtl/multicycle_adder_sub_pkg.sv
// Shared constants for the slice-serial adder/subtractor: FSM encoding and
// helpers that derive the slice count and slice-counter width.
package multicycle_adder_sub_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multicycle_adder_sub_if.sv
// Operand/result handshake bundle between the producer, the serial adder and
// the consumer.
interface multicycle_adder_sub_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             SUB;
    logic             C_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Z;
    logic             C_out;
    logic             OVF;

    modport master (
        output in_valid, X, Y, SUB, C_in, out_ready,
        input  in_ready, out_valid, Z, C_out, OVF
    );

    modport slave (
        input  in_valid, X, Y, SUB, C_in, out_ready,
        output in_ready, out_valid, Z, C_out, OVF
    );

endinterface

// File: rtl/multicycle_adder_sub_ripple.sv
// N-bit ripple-carry adder built from full adders; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module ripple_adder_n_bit #(
    parameter int N = 4
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         C_in,
    output logic [N-1:0] Z,
    output logic         C_out,
    output logic         C_msb_in
);
    logic [N:0] carry;

    assign carry[0] = C_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder fa (
            .a     (X[i]),
            .b     (Y[i]),
            .c_in  (carry[i]),
            .s     (Z[i]),
            .c_out (carry[i+1])
        );
    end

    assign C_out    = carry[N];
    assign C_msb_in = carry[N-1];
endmodule

// File: rtl/multicycle_adder_sub.sv
// Slice-serial adder/subtractor: one SLICE-bit ripple adder is reused over
// WIDTH/SLICE cycles with the carry held in a register between slices.
module multicycle_adder_sub
    import multicycle_adder_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input logic clk,
    input logic rst,
    multicycle_adder_sub_if.slave bus
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int KW     = cnt_width(NSLICE);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             carry;
    logic [WIDTH-1:0] z_q;
    logic             c_out_q;
    logic             ovf_q;

    int               base;
    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             last_slice;

    always_comb begin
        base       = int'(k) * SLICE;
        slice_x    = x_q[base +: SLICE];
        slice_y    = y_q[base +: SLICE];
        last_slice = (k == KW'(NSLICE - 1));
    end

    ripple_adder_n_bit #(.N(SLICE)) u_slice_adder (
        .X        (slice_x),
        .Y        (slice_y),
        .C_in     (carry),
        .Z        (slice_sum),
        .C_out    (slice_cout),
        .C_msb_in (slice_cmsb)
    );

    // Subtraction is folded into the operands at accept time, so RUN only
    // ever adds; the last slice's carries give C_out and signed overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            x_q     <= '0;
            y_q     <= '0;
            carry   <= 1'b0;
            z_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q   <= bus.X;
                        y_q   <= bus.SUB ? ~bus.Y : bus.Y;
                        carry <= bus.SUB ? ~bus.C_in : bus.C_in;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    z_q[base +: SLICE] <= slice_sum;
                    carry              <= slice_cout;
                    if (last_slice) begin
                        c_out_q <= slice_cout;
                        ovf_q   <= slice_cmsb ^ slice_cout;
                        k       <= '0;
                        state   <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.Z         = z_q;
    assign bus.C_out     = c_out_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder_sub.sv
// Self-checking bench: three instances (SLICE = 4, 1, 16) driven from a
// directed vector table, hand-written corner sequences and random operations.
module tb_multicycle_adder_sub;

    logic clk;
    logic rst;

    logic        iv[3];
    logic [15:0] xx[3];
    logic [15:0] yy[3];
    logic        sb[3];
    logic        ci[3];
    logic        ordy[3];
    logic        ir[3];
    logic        ov[3];
    logic [15:0] zz[3];
    logic        co[3];
    logic        of[3];

    int nsl[3] = '{4, 16, 1};

    int n_vec;
    int n_miss;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SL = (g == 0) ? 4 : ((g == 1) ? 1 : 16);

        multicycle_adder_sub_if #(.WIDTH(16)) bus ();

        assign bus.in_valid  = iv[g];
        assign bus.X         = xx[g];
        assign bus.Y         = yy[g];
        assign bus.SUB       = sb[g];
        assign bus.C_in      = ci[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign zz[g]         = bus.Z;
        assign co[g]         = bus.C_out;
        assign of[g]         = bus.OVF;

        multicycle_adder_sub #(.WIDTH(16), .SLICE(SL)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        sub;
        logic        cin;
        logic [15:0] z;
        logic        c;
        logic        o;
    } vec_t;

    vec_t tbl[6];

    // Reference: plain integer arithmetic, unsigned for Z/C_out, signed range
    // test for overflow; subtract C_out is "no borrow".
    function automatic void model(input logic [15:0] x, input logic [15:0] y,
                                  input logic sub, input logic cin,
                                  output logic [15:0] z, output logic c,
                                  output logic o);
        int ua, ub, sa, sb_i, ru, rs, cv;
        ua   = int'(x);
        ub   = int'(y);
        sa   = int'($signed(x));
        sb_i = int'($signed(y));
        cv   = cin ? 1 : 0;
        if (!sub) begin
            ru = ua + ub + cv;
            rs = sa + sb_i + cv;
            c  = (ru > 65535);
        end else begin
            ru = ua - ub - cv;
            rs = sa - sb_i - cv;
            c  = (ua >= ub + cv);
        end
        z = ru[15:0];
        o = (rs > 32767) || (rs < -32768);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on instance d: optional idle cycles, accept,
    // wait for out_valid, optional backpressure, then the output handshake.
    task automatic apply_stimulus(input int d, input logic [15:0] x,
                                  input logic [15:0] y, input logic sub,
                                  input logic cin, input int pre_stall,
                                  input int out_stall, output logic [15:0] z,
                                  output logic c, output logic o,
                                  output int lat, output bit ok);
        int budget;
        ok  = 1'b0;
        lat = 0;
        z   = '0;
        c   = 1'b0;
        o   = 1'b0;
        repeat (pre_stall) tick();
        budget = 0;
        while (!ir[d] && budget < 100) begin
            tick();
            budget++;
        end
        if (!ir[d]) begin
            check_output("in_ready_timeout", 32'(ir[d]), 32'd1);
            return;
        end
        iv[d] = 1'b1;
        xx[d] = x;
        yy[d] = y;
        sb[d] = sub;
        ci[d] = cin;
        tick();
        iv[d] = 1'b0;
        while (!ov[d] && lat < 100) begin
            tick();
            lat++;
        end
        if (!ov[d]) begin
            check_output("out_valid_timeout", 32'(ov[d]), 32'd1);
            return;
        end
        repeat (out_stall) tick();
        z = zz[d];
        c = co[d];
        o = of[d];
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        ok = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] z, ez, snap_z;
        logic        c, o, ec, eo, snap_c, snap_o;
        int          lat;
        bit          ok;

        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            xx[d]   = '0;
            yy[d]   = '0;
            sb[d]   = 1'b0;
            ci[d]   = 1'b0;
            ordy[d] = 1'b0;
        end

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};

        #12;
        for (int d = 0; d < 3; d++) begin
            check_output("reset_in_ready", 32'(ir[d]), 32'd1);
            check_output("reset_out_valid", 32'(ov[d]), 32'd0);
            check_output("reset_z", 32'(zz[d]), 32'd0);
            check_output("reset_c_out", 32'(co[d]), 32'd0);
            check_output("reset_ovf", 32'(of[d]), 32'd0);
        end
        #1 rst = 1'b0;
        tick();

        // Directed vectors on every slice width, including exact latency.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
                apply_stimulus(d, tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].cin,
                               0, 0, z, c, o, lat, ok);
                if (ok) begin
                    check_output("table_z", 32'(z), 32'(tbl[i].z));
                    check_output("table_c_out", 32'(c), 32'(tbl[i].c));
                    check_output("table_ovf", 32'(o), 32'(tbl[i].o));
                    check_output("table_latency", 32'(lat), 32'(nsl[d]));
                end
            end
        end

        // Backpressure in DONE with in_valid pulsing: result must hold and
        // nothing new may be accepted, including on the handshake edge.
        iv[0] = 1'b1;
        xx[0] = 16'h1111;
        yy[0] = 16'h2222;
        sb[0] = 1'b0;
        ci[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (nsl[0]) tick();
        check_output("bp_out_valid", 32'(ov[0]), 32'd1);
        model(16'h1111, 16'h2222, 1'b0, 1'b1, ez, ec, eo);
        snap_z = zz[0];
        snap_c = co[0];
        snap_o = of[0];
        check_output("bp_z", 32'(snap_z), 32'(ez));
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1;
            xx[0] = 16'($urandom);
            yy[0] = 16'($urandom);
            tick();
            check_output("bp_hold_valid", 32'(ov[0]), 32'd1);
            check_output("bp_hold_ready", 32'(ir[0]), 32'd0);
            check_output("bp_hold_z", 32'(zz[0]), 32'(ez));
            check_output("bp_hold_c_out", 32'(co[0]), 32'(ec));
            check_output("bp_hold_ovf", 32'(of[0]), 32'(eo));
        end
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        iv[0]   = 1'b0;
        check_output("bp_after_ready", 32'(ir[0]), 32'd1);
        check_output("bp_after_valid", 32'(ov[0]), 32'd0);
        repeat (nsl[0] + 2) tick();
        check_output("bp_no_accept", 32'(ov[0]), 32'd0);

        // Asynchronous reset while slice k=2 is pending.
        iv[0] = 1'b1;
        xx[0] = 16'hFFFF;
        yy[0] = 16'h0001;
        sb[0] = 1'b0;
        ci[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        check_output("rst_run_out_valid", 32'(ov[0]), 32'd0);
        check_output("rst_run_z", 32'(zz[0]), 32'd0);
        check_output("rst_run_in_ready", 32'(ir[0]), 32'd1);
        #1 rst = 1'b0;
        tick();
        apply_stimulus(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 0, z, c, o, lat, ok);
        if (ok) begin
            check_output("post_rst_z", 32'(z), 32'h2345);
            check_output("post_rst_c_out", 32'(c), 32'd0);
            check_output("post_rst_ovf", 32'(o), 32'd0);
        end

        // Random operations with input and output stalls against the model.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 340; n++) begin
                logic [15:0] rx, ry;
                logic        rs, rc;
                rx = 16'($urandom);
                ry = 16'($urandom);
                rs = 1'($urandom);
                rc = 1'($urandom);
                if (n % 8 == 0) ry = rx;
                model(rx, ry, rs, rc, ez, ec, eo);
                apply_stimulus(d, rx, ry, rs, rc, int'($urandom_range(0, 2)),
                               int'($urandom_range(0, 3)), z, c, o, lat, ok);
                if (ok) begin
                    check_output("rand_z", 32'(z), 32'(ez));
                    check_output("rand_c_out", 32'(c), 32'(ec));
                    check_output("rand_ovf", 32'(o), 32'(eo));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_adder_sub.md
# multicycle_adder_sub

Parametrised, slice-serial adder/subtractor that computes a WIDTH-bit sum or difference over WIDTH/SLICE clock cycles, reusing one SLICE-bit ripple adder with a registered carry between slices. It sits between operand-producing and result-consuming blocks in the arithmetic datapath, with valid/ready handshakes on both sides. It supports carry/borrow-in, carry-out and signed-overflow reporting. It suits wide operands where a full-width ripple chain would not meet timing.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of SLICE, ≥ 2
- SLICE, 4, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- X  in  WIDTH  operand A
- Y  in  WIDTH  operand B
- SUB  in  1  0: add; 1: subtract
- C_in  in  1  carry-in (add) / borrow-in (subtract)
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- Z  out  WIDTH  result
- C_out  out  1  raw carry out of MSB
- OVF  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, latch X, Y' = SUB ? ~Y : Y, carry = SUB ? ~C_in : C_in, and SUB. Clear slice counter k=0. Go to RUN.
- Add: Z = X + Y + C_in. Subtract: Z = X − Y − C_in, computed as X + ~Y + ~C_in.
- RUN: each edge adds slice k, bits [k·SLICE +: SLICE], of latched X and Y' plus the carry register. Writes the slice into Z, updates the carry register, and increments k.
- On the edge that processes the last slice (k = NSLICE−1):
  - C_out = final carry. For subtract, C_out=1 means no borrow.
  - OVF = carry into MSB XOR carry out of MSB.
  - Go to DONE.
- DONE: out_valid=1. Z, C_out and OVF are held stable until out_ready=1 at an edge, then go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored outside IDLE. No operand is accepted in the DONE→IDLE handoff cycle.
- Z, C_out and OVF are registered. Z is undefined-but-stable while out_valid=0; the bench only checks it when out_valid=1.
- Reset (any state, including mid-RUN): state=IDLE, k=0, carry=0, Z=0, C_out=0, OVF=0, out_valid=0. In-flight operation is discarded. in_ready reads 1 during and after reset (decoded from IDLE).

## Timing
- NSLICE = WIDTH/SLICE.
- Accept edge t (IDLE, in_valid=1). Slices processed on edges t+1 … t+NSLICE. out_valid=1 from edge t+NSLICE.
- Latency, accept to out_valid: NSLICE cycles.
- Minimum initiation interval: NSLICE + 2 cycles (accept, NSLICE RUN edges, output handshake). Example: WIDTH=16, SLICE=4 gives 6 cycles.
- out_valid, once asserted, never drops without an out_ready handshake, except on RST.
- Combinational path per cycle: one SLICE-bit ripple plus carry register; no full-width chain.
- WIDTH=SLICE degenerates to one RUN cycle; behaviour is otherwise identical.

## Structure
- Shared package/header holds:
  - state encoding constants IDLE/RUN/DONE (2-bit);
  - the derived NSLICE and counter width $clog2(NSLICE) (minimum 1).
- One sub-module, ripple_adder_n_bit: combinational, parameter N = SLICE, ports X, Y, C_in, Z, C_out, plus C_msb_in (carry into its top bit) for OVF. Built from full_adder instances via generate.
- Top level holds the FSM, slice counter, operand and result registers, and slice select/insert muxing.

## Test plan
Defaults WIDTH=16, SLICE=4.
- Add 0x00FF + 0x0001, C_in=0 → Z=0x0100, C_out=0, OVF=0; out_valid exactly 4 cycles after the accept edge.
- Add 0x7FFF + 0x0001 → Z=0x8000, OVF=1, C_out=0. Then 0xFFFF + 0xFFFF, C_in=1 → Z=0xFFFF, C_out=1, OVF=0.
- Subtract 0x0005 − 0x0007, C_in=0 → Z=0xFFFE, C_out=0, OVF=0. Subtract 0x8000 − 0x0001 → Z=0x7FFF, OVF=1, C_out=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands → Z/C_out/OVF unchanged, in_ready=0, new operands not accepted; in_ready=1 one cycle after the out_ready handshake.
- Reset asserted asynchronously at k=2 of RUN → out_valid=0, Z=0, in_ready=1 immediately. The next operation (0x1234 + 0x1111) completes normally, giving Z=0x2345.
- Random 1000 operations at SLICE ∈ {1, 4, 16} with random in_valid/out_ready stalls → Z/C_out/OVF match the reference model every time.
